// File: rtl/sbinit_ctrl_pkg.sv
// Sideband message encodings shared by the LTSM states and the SB TX/RX mux.
package sbinit_ctrl_pkg;

    typedef enum logic [3:0] {
        NOP                     = 4'd0,
        SBINIT_OUT_OF_RESET     = 4'd1,
        SBINIT_DONE_REQ         = 4'd2,
        SBINIT_DONE_RESP        = 4'd3,
        MBINIT_PARAM_CONFIG_REQ = 4'd4
    } SB_msg_t;

endpackage

// File: rtl/sbinit_ctrl.sv
// SBINIT controller: SB clock-pattern exchange followed by the out-of-reset
// and done request/response handshake with the link partner.
module sbinit_ctrl
    import sbinit_ctrl_pkg::*;
#(
    parameter int unsigned PATTERN_TAIL_ITER = 4,
    parameter int unsigned ITER_CYCLES       = 128,
    parameter logic [63:0] DATA_ZERO         = 64'h0
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        enable_i,
    output logic        SBINIT_done_o,
    output logic        SB_pattern_en_o,
    input  logic        SB_pattern_detected_i,
    output SB_msg_t     SB_TX_msg_o,
    output logic [63:0] SB_TX_dataBus_o,
    output logic        SB_TX_msg_valid_o,
    input  logic        SB_TX_msg_sendNextFlag_i,
    input  SB_msg_t     SB_RX_msg_i,
    input  logic [63:0] SB_RX_dataBus_i,
    output logic        SB_RX_msg_req_o,
    input  logic        SB_RX_msg_valid_i,
    output logic        reset_state_timeout_counter_o
);

    localparam int unsigned TAIL_CYCLES = PATTERN_TAIL_ITER * ITER_CYCLES;
    localparam int unsigned CNT_MAX     = (TAIL_CYCLES > ITER_CYCLES) ? TAIL_CYCLES : ITER_CYCLES;
    localparam int unsigned CNT_W       = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PATTERN      = 3'd1,
        PATTERN_TAIL = 3'd2,
        OOR          = 3'd3,
        DONE_XCHG    = 3'd4,
        DONE         = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_oor_q, tx_oor_d;
    logic               rx_oor_q, rx_oor_d;
    logic               rx_req_q, rx_req_d;
    logic               rx_resp_q, rx_resp_d;
    logic               req_sent_q, req_sent_d;
    logic               resp_sent_q, resp_sent_d;
    logic               done_q, done_d;
    logic               pattern_en_q, pattern_en_d;
    SB_msg_t            tx_msg_q, tx_msg_d;
    logic [63:0]        tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               rx_msg_req_q, rx_msg_req_d;
    logic               timeout_rst_q, timeout_rst_d;
    logic               tx_acc_c, rx_acc_c;
    logic               rx_data_unused;

    assign rx_data_unused = ^SB_RX_dataBus_i;

    // Next state, handshake flags and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_oor_d    = tx_oor_q;
        rx_oor_d    = rx_oor_q;
        rx_req_d    = rx_req_q;
        rx_resp_d   = rx_resp_q;
        req_sent_d  = req_sent_q;
        resp_sent_d = resp_sent_q;
        tx_valid_d  = 1'b0;
        tx_msg_d    = NOP;
        tx_acc_c    = tx_valid_q && SB_TX_msg_sendNextFlag_i;
        rx_acc_c    = rx_msg_req_q && SB_RX_msg_valid_i;

        if (!enable_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            tx_oor_d    = 1'b0;
            rx_oor_d    = 1'b0;
            rx_req_d    = 1'b0;
            rx_resp_d   = 1'b0;
            req_sent_d  = 1'b0;
            resp_sent_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PATTERN;
                    cnt_d   = '0;
                end
                PATTERN: begin
                    if (cnt_q == CNT_W'(ITER_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (SB_pattern_detected_i) state_d = PATTERN_TAIL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PATTERN_TAIL: begin
                    if (cnt_q == CNT_W'(TAIL_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = OOR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OOR: begin
                    if (tx_acc_c && tx_msg_q == SBINIT_OUT_OF_RESET) tx_oor_d = 1'b1;
                    // An early partner DONE_REQ is kept so it is answered in DONE_XCHG.
                    if (rx_acc_c && SB_RX_msg_i == SBINIT_OUT_OF_RESET) rx_oor_d = 1'b1;
                    if (rx_acc_c && SB_RX_msg_i == SBINIT_DONE_REQ)     rx_req_d = 1'b1;
                    if (tx_oor_d && rx_oor_d) state_d = DONE_XCHG;
                end
                DONE_XCHG: begin
                    if (tx_acc_c && tx_msg_q == SBINIT_DONE_REQ)  req_sent_d  = 1'b1;
                    if (tx_acc_c && tx_msg_q == SBINIT_DONE_RESP) resp_sent_d = 1'b1;
                    if (rx_acc_c && SB_RX_msg_i == SBINIT_DONE_REQ)  rx_req_d  = 1'b1;
                    if (rx_acc_c && SB_RX_msg_i == SBINIT_DONE_RESP) rx_resp_d = 1'b1;
                    if (req_sent_d && rx_resp_d && resp_sent_d) state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        // TX message stays put until accepted; own DONE_REQ goes out before DONE_RESP.
        if (state_d == OOR && !tx_oor_d) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = SBINIT_OUT_OF_RESET;
        end else if (state_d == DONE_XCHG && !req_sent_d) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = SBINIT_DONE_REQ;
        end else if (state_d == DONE_XCHG && rx_req_d && !resp_sent_d) begin
            tx_valid_d = 1'b1;
            tx_msg_d   = SBINIT_DONE_RESP;
        end

        tx_data_d     = tx_valid_d ? DATA_ZERO : 64'h0;
        pattern_en_d  = (state_d == PATTERN) || (state_d == PATTERN_TAIL);
        rx_msg_req_d  = (state_d == OOR) || (state_d == DONE_XCHG);
        done_d        = (state_d == DONE);
        timeout_rst_d = (state_d != state_q);
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tx_oor_q      <= 1'b0;
            rx_oor_q      <= 1'b0;
            rx_req_q      <= 1'b0;
            rx_resp_q     <= 1'b0;
            req_sent_q    <= 1'b0;
            resp_sent_q   <= 1'b0;
            done_q        <= 1'b0;
            pattern_en_q  <= 1'b0;
            tx_msg_q      <= NOP;
            tx_data_q     <= 64'h0;
            tx_valid_q    <= 1'b0;
            rx_msg_req_q  <= 1'b0;
            timeout_rst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_oor_q      <= tx_oor_d;
            rx_oor_q      <= rx_oor_d;
            rx_req_q      <= rx_req_d;
            rx_resp_q     <= rx_resp_d;
            req_sent_q    <= req_sent_d;
            resp_sent_q   <= resp_sent_d;
            done_q        <= done_d;
            pattern_en_q  <= pattern_en_d;
            tx_msg_q      <= tx_msg_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            rx_msg_req_q  <= rx_msg_req_d;
            timeout_rst_q <= timeout_rst_d;
        end
    end

    assign SBINIT_done_o                 = done_q;
    assign SB_pattern_en_o               = pattern_en_q;
    assign SB_TX_msg_o                   = tx_msg_q;
    assign SB_TX_dataBus_o               = tx_data_q;
    assign SB_TX_msg_valid_o             = tx_valid_q;
    assign SB_RX_msg_req_o               = rx_msg_req_q;
    assign reset_state_timeout_counter_o = timeout_rst_q;

endmodule
